freq_ascii_formatter: RTL and testbench

Converts the binary LO frequency word produced by the frequency-calculation stage into a human-readable ASCII decimal string and writes it byte-by-byte into the RS232 transmit FIFO. It sits between freq_calc (producer of `freq_hz` + `start`) and tx_module (consumer of `tx_data` / `tx_fifo_wr`). Conversion uses sequential double-dabble, one bit per clock. Output respects FIFO back-pressure.

---
 rtl/freq_ascii_formatter.sv | 139 +++++++++++++
 tb/tb_freq_ascii_formatter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_ascii_formatter.sv
// Binary-to-ASCII decimal formatter: sequential double-dabble conversion, then
// leading-zero suppression and byte-wise writes into the TX FIFO with back-pressure.
module freq_ascii_formatter #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned DIGITS    = 10,
  parameter bit          SEND_CRLF = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] freq_hz,
  input  logic                tx_fifo_full,
  output logic [7:0]          tx_data,
  output logic                tx_fifo_wr,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SKIP,
    S_SEND_DIG,
    S_SEND_CR,
    S_SEND_LF,
    S_FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [IN_WIDTH-1:0]   shift_q, shift_d;
  logic [DIGITS*4-1:0]   bcd_q, bcd_d, bcd_adj;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [7:0]            tx_data_q, tx_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr;

  // The only combinational input path: a write is gated directly by the full flag.
  assign wr = ((state_q == S_SEND_DIG) || (state_q == S_SEND_CR) || (state_q == S_SEND_LF))
              && !tx_fifo_full;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bcd_d     = bcd_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    bcd_adj   = bcd_q;

    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_d = freq_hz;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(IN_WIDTH - 1)) begin
          idx_d   = IDX_W'(DIGITS - 1);
          state_d = S_SKIP;
        end
      end
      S_SKIP: begin
        if ((bcd_q[idx_q*4 +: 4] == 4'd0) && (idx_q != '0)) begin
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = S_SEND_DIG;
        end
      end
      S_SEND_DIG: begin
        if (wr) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else begin
            state_d = SEND_CRLF ? S_SEND_CR : S_FINISH;
          end
        end
      end
      S_SEND_CR: if (wr) state_d = S_SEND_LF;
      S_SEND_LF: if (wr) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    // tx_data is registered from the next digit index so it is stable for the whole send state.
    case (state_d)
      S_SEND_DIG: tx_data_d = 8'h30 + {4'h0, bcd_q[idx_d*4 +: 4]};
      S_SEND_CR:  tx_data_d = 8'h0D;
      S_SEND_LF:  tx_data_d = 8'h0A;
      default:    tx_data_d = tx_data_q;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
    done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_fifo_wr = wr;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_freq_ascii_formatter.sv
// Self-checking bench for freq_ascii_formatter: expected strings and timing come
// from a decimal-arithmetic model of the value, not from the conversion algorithm.
module tb_freq_ascii_formatter;

  localparam int unsigned IN_WIDTH = 32;
  localparam int unsigned DIGITS   = 10;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                start = 1'b0;
  logic                tx_fifo_full = 1'b0;
  logic [IN_WIDTH-1:0] freq_hz = '0;
  logic [7:0]          tx_data;
  logic                tx_fifo_wr;
  logic                busy;
  logic                done;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  byte unsigned wq[$];
  int unsigned  wcyc[$];
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  logic        busy_at_done = 1'b0;
  int          bad_full = 0;

  freq_ascii_formatter #(
    .IN_WIDTH (IN_WIDTH),
    .DIGITS   (DIGITS),
    .SEND_CRLF(1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .freq_hz     (freq_hz),
    .tx_fifo_full(tx_fifo_full),
    .tx_data     (tx_data),
    .tx_fifo_wr  (tx_fifo_wr),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte/done log sampled mid-cycle; the reset cycle itself is not logged.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_fifo_wr) begin
        wq.push_back(tx_data);
        wcyc.push_back(cyc);
        if (tx_fifo_full) bad_full++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  function automatic string model_str(input logic [IN_WIDTH-1:0] v);
    string s;
    longint unsigned x;
    byte unsigned b;
    s = "";
    x = v;
    do begin
      b = 8'(48 + (x % 10));
      s = {$sformatf("%02h ", b), s};
      x = x / 10;
    end while (x != 0);
    return {s, "0d 0a "};
  endfunction

  function automatic int model_ndig(input logic [IN_WIDTH-1:0] v);
    longint unsigned x;
    int n;
    x = v;
    n = 0;
    do begin
      n++;
      x = x / 10;
    end while (x != 0);
    return n;
  endfunction

  function automatic string q2s(input byte unsigned q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic clear_log;
    wq.delete();
    wcyc.delete();
    bad_full = 0;
  endtask

  task automatic pulse_start(input logic [IN_WIDTH-1:0] v);
    @(posedge clk); #1;
    freq_hz = v;
    start   = 1'b1;
    c0      = cyc;
    @(posedge clk); #1;
    start   = 1'b0;
    freq_hz = IN_WIDTH'($urandom);
  endtask

  task automatic wait_done(input int bound, input bit rand_full, output bit ok);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < bound) begin
      if (rand_full) tx_fifo_full = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
      n++;
    end
    tx_fifo_full = 1'b0;
    ok = (done_cnt != d0);
  endtask

  task automatic wait_first_byte(output bit ok);
    int n;
    n = 0;
    while (wq.size() == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (wq.size() != 0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    tx_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({tx_fifo_wr, busy, done} !== 3'b000)
      $display("FAIL reset_ctrl: wr/busy/done=%b expected 000", {tx_fifo_wr, busy, done});
    tests++;
    if (tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_data: tx_data=%02h expected 00", tx_data);
    end
    if ({tx_fifo_wr, busy, done} !== 3'b000) fails++;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({tx_fifo_wr, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: wr/busy/done=%b expected 000", {tx_fifo_wr, busy, done});
    end
  endtask

  task automatic test_zero;
    bit ok;
    int fw;
    clear_log();
    pulse_start('0);
    wait_done(300, 1'b0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL zero_timeout: done=0 expected 1"); end
    tests++;
    if (q2s(wq) != "30 0d 0a ") begin
      fails++;
      $display("FAIL zero_bytes: got %s expected 30 0d 0a", q2s(wq));
    end
    fw = (wcyc.size() > 0) ? int'(wcyc[0] - c0) : -1;
    tests++;
    if (fw != 43) begin fails++; $display("FAIL zero_first_wr: cycle %0d expected 43", fw); end
    tests++;
    if (int'(done_cyc - c0) != 46) begin
      fails++;
      $display("FAIL zero_done: cycle %0d expected 46", int'(done_cyc - c0));
    end
  endtask

  task automatic test_known;
    logic [IN_WIDTH-1:0] vals[6];
    bit ok;
    int fw, n, exp_fw;
    vals = '{32'd123456789, 32'hFFFF_FFFF, 32'd1, 32'd9, 32'd10, 32'd1000000000};
    foreach (vals[k]) begin
      clear_log();
      pulse_start(vals[k]);
      wait_done(300, 1'b0, ok);
      n      = wq.size();
      exp_fw = 2 + IN_WIDTH + DIGITS - model_ndig(vals[k]);
      fw     = (n > 0) ? int'(wcyc[0] - c0) : -1;
      tests++;
      if (!ok || q2s(wq) != model_str(vals[k])) begin
        fails++;
        $display("FAIL known_bytes(%0d): got %s expected %s", vals[k], q2s(wq), model_str(vals[k]));
      end
      tests++;
      if (fw != exp_fw) begin
        fails++;
        $display("FAIL known_first_wr(%0d): cycle %0d expected %0d", vals[k], fw, exp_fw);
      end
      tests++;
      if (n == 0 || int'(wcyc[n-1] - wcyc[0]) != n - 1 || done_cyc != wcyc[n-1] + 1 || busy_at_done !== 1'b0) begin
        fails++;
        $display("FAIL known_stream(%0d): done at %0d busy=%b, expected back-to-back writes then done, busy 0",
                 vals[k], int'(done_cyc - c0), busy_at_done);
      end
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    int viol;
    clear_log();
    pulse_start(32'd108);
    wait_first_byte(ok);
    tx_fifo_full = 1'b1;
    viol = 0;
    repeat (5) begin
      @(negedge clk);
      if (tx_fifo_wr !== 1'b0 || tx_data !== 8'h30) viol++;
      @(posedge clk); #1;
    end
    tx_fifo_full = 1'b0;
    wait_done(300, 1'b0, ok);
    tests++;
    if (viol != 0) begin
      fails++;
      $display("FAIL stall_hold: %0d bad stall cycles expected 0", viol);
    end
    tests++;
    if (!ok || q2s(wq) != "31 30 38 0d 0a ") begin
      fails++;
      $display("FAIL stall_bytes: got %s expected 31 30 38 0d 0a", q2s(wq));
    end
  endtask

  task automatic test_ignore_start;
    bit ok;
    logic busy_seen;
    clear_log();
    pulse_start(32'd42);
    repeat (4) begin @(posedge clk); #1; end
    busy_seen = busy;
    freq_hz = 32'd999;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_done(300, 1'b0, ok);
    tests++;
    if (busy_seen !== 1'b1) begin fails++; $display("FAIL busy_mid_convert: busy=%b expected 1", busy_seen); end
    tests++;
    if (!ok || q2s(wq) != "34 32 0d 0a ") begin
      fails++;
      $display("FAIL ignore_bytes: got %s expected 34 32 0d 0a", q2s(wq));
    end
    clear_log();
    pulse_start(32'd999);
    wait_done(300, 1'b0, ok);
    tests++;
    if (!ok || q2s(wq) != "39 39 39 0d 0a ") begin
      fails++;
      $display("FAIL back_to_back_bytes: got %s expected 39 39 39 0d 0a", q2s(wq));
    end
  endtask

  task automatic test_reset_abort;
    bit ok;
    int viol;
    clear_log();
    pulse_start(32'd555);
    wait_first_byte(ok);
    tests++;
    if (!ok || wq[0] != 8'h35) begin fails++; $display("FAIL abort_first: got %s expected 35", q2s(wq)); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_fifo_wr !== 1'b0 || busy !== 1'b0) viol++;
      @(posedge clk); #1;
    end
    tests++;
    if (viol != 0 || wq.size() != 1) begin
      fails++;
      $display("FAIL abort_quiet: %0d active cycles, %0d bytes; expected 0 active, 1 byte", viol, wq.size());
    end
    clear_log();
    pulse_start(32'd7);
    wait_done(300, 1'b0, ok);
    tests++;
    if (!ok || q2s(wq) != "37 0d 0a ") begin
      fails++;
      $display("FAIL after_abort_bytes: got %s expected 37 0d 0a", q2s(wq));
    end
  endtask

  task automatic test_random_backpressure;
    bit ok;
    logic [IN_WIDTH-1:0] v;
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 2))
        0:       v = IN_WIDTH'($urandom);
        1:       v = IN_WIDTH'($urandom_range(0, 99));
        default: v = IN_WIDTH'($urandom_range(0, 999999));
      endcase
      clear_log();
      pulse_start(v);
      wait_done(3000, 1'b1, ok);
      tests++;
      if (!ok || q2s(wq) != model_str(v) || bad_full != 0 || busy_at_done !== 1'b0) begin
        fails++;
        $display("FAIL random_bp(%0d): got %s (full-writes %0d) expected %s",
                 v, q2s(wq), bad_full, model_str(v));
      end
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero();
    test_known();
    test_backpressure();
    test_ignore_start();
    test_reset_abort();
    test_random_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
